// File: rtl/lcd_hex_formatter.sv
// lcd_hex_formatter: renders NCH status channels as upper-case ASCII hex into a
// character line and offers each complete line to the LCD driver via req/ack.
// A line is built one digit per cycle in a work buffer and published atomically.
module lcd_hex_formatter #(
  parameter int NCH         = 4,
  parameter int W           = 16,
  parameter int GAP         = 1,
  parameter int LINE_CHARS  = 32,
  parameter int REFRESH_MIN = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NCH*W-1:0]        ch_i,
  input  logic                    force_i,
  input  logic                    freeze_i,
  input  logic                    blank_i,
  output logic                    req_o,
  input  logic                    ack_i,
  output logic [8*LINE_CHARS-1:0] line_o,
  output logic                    busy_o
);

  localparam int D    = W / 4;
  localparam int NDIG = NCH * D;
  localparam int USED = NCH * (D + GAP) - GAP;
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int TW   = (REFRESH_MIN > 0) ? $clog2(REFRESH_MIN + 1) : 1;

  localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);
  localparam logic [TW-1:0] CNT_INIT = TW'(REFRESH_MIN);
  localparam logic [TW-1:0] CNT_ONE  = TW'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_REQ  = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  if ((W % 4) != 0 || W < 4) begin : g_bad_width
    $error("lcd_hex_formatter: W must be a positive multiple of 4");
  end
  if (USED > LINE_CHARS) begin : g_bad_line
    $error("lcd_hex_formatter: channel fields do not fit in LINE_CHARS");
  end

  logic [1:0]              state;
  logic [NCH*W-1:0]        snap;
  logic                    blank_s;
  logic                    pend;
  logic [IW-1:0]           idx;
  logic [TW-1:0]           cnt;
  logic                    lz_q;
  logic [7:0]              digs [NDIG];
  logic [3:0]              nib_arr [NDIG];
  logic [NDIG-1:0]         first_v;
  logic [NDIG-1:0]         last_v;
  logic [8*LINE_CHARS-1:0] line_nxt;

  logic       trig;
  logic [3:0] nib;
  logic       lz_now;
  logic [7:0] cur_char;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Static map from digit index to its nibble in the snapshot (MS nibble first)
  for (genvar j = 0; j < NDIG; j++) begin : g_dig_map
    assign nib_arr[j] = snap[(j / D) * W + (D - 1 - (j % D)) * 4 +: 4];
    assign first_v[j] = ((j % D) == 0);
    assign last_v[j]  = ((j % D) == (D - 1));
  end

  // Work line: stored digits plus the digit being written this cycle; fixed spaces elsewhere
  for (genvar p = 0; p < LINE_CHARS; p++) begin : g_line
    if ((p / (D + GAP)) < NCH && (p % (D + GAP)) < D) begin : g_digit
      localparam int J = (p / (D + GAP)) * D + (p % (D + GAP));
      assign line_nxt[8*(LINE_CHARS-p)-1 -: 8] = (idx == IW'(J)) ? cur_char : digs[J];
    end else begin : g_space
      assign line_nxt[8*(LINE_CHARS-p)-1 -: 8] = 8'h20;
    end
  end

  assign trig = ((snap != ch_i) || pend) && !freeze_i;

  // Current digit: leading-zero tracking restarts at each channel's MS nibble
  always_comb begin
    nib      = nib_arr[idx];
    lz_now   = (first_v[idx] ? 1'b1 : lz_q) && (nib == 4'h0);
    cur_char = (blank_s && lz_now && !last_v[idx]) ? 8'h20 : hex_char(nib);
  end

  // Work buffer and leading-zero flag; pure data, overwritten before use
  always_ff @(posedge clk) begin
    if (state == S_CONV) begin
      digs[idx] <= cur_char;
      lz_q      <= lz_now;
    end
  end

  // Control FSM, snapshot, published line and handshake outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      req_o   <= 1'b0;
      busy_o  <= 1'b0;
      line_o  <= {LINE_CHARS{8'h20}};
      snap    <= '0;
      blank_s <= 1'b0;
      pend    <= 1'b1;
      cnt     <= '0;
      idx     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (trig) begin
            snap    <= ch_i;
            blank_s <= blank_i;
            pend    <= 1'b0;
            idx     <= '0;
            state   <= S_CONV;
            busy_o  <= 1'b1;
          end
        end
        S_CONV: begin
          if (idx == IDX_LAST) begin
            line_o <= line_nxt;
            state  <= S_REQ;
            req_o  <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_REQ: begin
          if (ack_i) begin
            req_o <= 1'b0;
            if (REFRESH_MIN == 0) begin
              state  <= S_IDLE;
              busy_o <= 1'b0;
            end else begin
              state <= S_HOLD;
              cnt   <= CNT_INIT;
            end
          end
        end
        default: begin
          cnt <= cnt - 1'b1;
          if (cnt <= CNT_ONE) begin
            state  <= S_IDLE;
            busy_o <= 1'b0;
          end
        end
      endcase
      // a force request is never lost, even when it coincides with a start
      if (force_i) pend <= 1'b1;
    end
  end

endmodule
